// File: rtl/hazard_controller_pkg.sv
// Shared defaults and count type for the pipeline hazard controller.
package hazard_controller_pkg;

   localparam int HC_REG_AW_DEF      = 3;
   localparam int HC_LOAD_LAT_DEF    = 1;
   localparam int HC_FLUSH_DEPTH_DEF = 1;
   localparam int HC_CNT_W_DEF       = 16;

   localparam int HC_CNT_BITS = 3;
   typedef logic [HC_CNT_BITS-1:0] hc_cnt_t;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating stall/flush cycle counters for the hazard controller.
module hazard_perf_counters
   import hazard_controller_pkg::*;
#(
   parameter int CNT_W = HC_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, memory-wait holds.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int REG_AW      = HC_REG_AW_DEF,
   parameter int LOAD_LAT    = HC_LOAD_LAT_DEF,
   parameter int FLUSH_DEPTH = HC_FLUSH_DEPTH_DEF,
   parameter int CNT_W       = HC_CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_ex_rt,
   input  logic              id_ex_mem_read,
   input  logic              mem_req,
   input  logic              mem_ready,
   input  logic              branch_taken,
   input  logic              jump,
   input  logic              jump_reg,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic              pipe_hold,
   output logic              stall,
   output logic              flush
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   typedef enum logic [1:0] {RUN, LD_STALL, FLUSH, MEM_WAIT} state_t;

   if (LOAD_LAT < 1 || LOAD_LAT > 8) begin : g_bad_load_lat
      $error("hazard_controller: LOAD_LAT must be 1..8");
   end
   if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 4) begin : g_bad_flush_depth
      $error("hazard_controller: FLUSH_DEPTH must be 1..4");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("hazard_controller: CNT_W must be at least 1");
   end

   localparam hc_cnt_t LD_INIT = hc_cnt_t'(LOAD_LAT - 1);
   localparam hc_cnt_t FL_INIT = hc_cnt_t'(FLUSH_DEPTH - 1);
   localparam hc_cnt_t ONE     = hc_cnt_t'(1);

   state_t  state, state_n, saved, saved_n, eff;
   hc_cnt_t cnt, cnt_n;
   logic    load_use, mem_wait, control;

   assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                     ((id_uses_rs && (id_rs == id_ex_rt)) ||
                      (id_uses_rt && (id_rt == id_ex_rt)));
   assign mem_wait = mem_req && !mem_ready;
   assign control  = branch_taken || jump || jump_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         saved <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         saved <= saved_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n        = state;
      saved_n        = saved;
      cnt_n          = cnt;
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_bubble   = 1'b0;
      pipe_hold      = 1'b0;
      eff            = (state == MEM_WAIT) ? saved : state;
      if (rst) begin
         state_n = RUN;
      end else if (mem_wait) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         pipe_hold      = 1'b1;
         if (state != MEM_WAIT) begin
            saved_n = state;
            state_n = MEM_WAIT;
         end
      end else begin
         // The release cycle already performs the saved state's work, so a
         // held stall or flush resumes without an idle gap.
         state_n = eff;
         case (eff)
            RUN: begin
               if (state != MEM_WAIT) begin
                  if (load_use) begin
                     pc_write_en    = 1'b0;
                     if_id_write_en = 1'b0;
                     id_ex_bubble   = 1'b1;
                     if (LOAD_LAT > 1) begin
                        state_n = LD_STALL;
                        cnt_n   = LD_INIT;
                     end
                  end else if (control) begin
                     if_id_flush = 1'b1;
                     if (FLUSH_DEPTH > 1) begin
                        state_n = FLUSH;
                        cnt_n   = FL_INIT;
                     end
                  end
               end
            end
            LD_STALL: begin
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_bubble   = 1'b1;
               if (cnt > ONE) cnt_n = cnt - ONE;
               else           state_n = RUN;
            end
            FLUSH: begin
               if_id_flush = 1'b1;
               if (cnt > ONE) cnt_n = cnt - ONE;
               else           state_n = RUN;
            end
            default: state_n = RUN;
         endcase
      end
   end

   assign stall = !pc_write_en;
   assign flush = if_id_flush;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .flush     (flush),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two parameterisations checked every cycle against a
// remaining-work model, plus directed scenarios with hand-computed totals.
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] id_rs, id_rt, id_ex_rt;
   logic       id_uses_rs, id_uses_rt, id_ex_mem_read, mem_req, mem_ready;
   logic       branch_taken, jump, jump_reg;

   logic a_pc, a_ifw, a_ifl, a_bub, a_hold, a_stall, a_flush;
   logic b_pc, b_ifw, b_ifl, b_bub, b_hold, b_stall, b_flush;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] a_scnt, a_fcnt;
   logic [2:0]  b_scnt, b_fcnt;
`endif
   logic       p_stall = 1'b0, p_flush = 1'b0;
   logic [2:0] p_scnt, p_fcnt;

   int n_tests = 0;
   int n_fail  = 0;
   int a_st, b_st, a_fl, b_fl, a_ho, b_ho;

   always #5 clk = ~clk;

   hazard_controller u1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
      .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .jump(jump), .jump_reg(jump_reg), .pc_write_en(a_pc), .if_id_write_en(a_ifw),
      .if_id_flush(a_ifl), .id_ex_bubble(a_bub), .pipe_hold(a_hold),
      .stall(a_stall), .flush(a_flush)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
`endif
   );

   hazard_controller #(.LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(3)) u3 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
      .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .jump(jump), .jump_reg(jump_reg), .pc_write_en(b_pc), .if_id_write_en(b_ifw),
      .if_id_flush(b_ifl), .id_ex_bubble(b_bub), .pipe_hold(b_hold),
      .stall(b_stall), .flush(b_flush)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
`endif
   );

   hazard_perf_counters #(.CNT_W(3)) u_pc (
      .clk(clk), .rst(rst), .stall(p_stall), .flush(p_flush),
      .stall_cnt(p_scnt), .flush_cnt(p_fcnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: remaining stall/flush cycles per configuration; memory wait freezes them.
   int   lat[2]  = '{1, 3};
   int   dep[2]  = '{1, 2};
   int   cap[2]  = '{65535, 7};
   int   srem[2] = '{0, 0};
   int   frem[2] = '{0, 0};
   int   pcs[2]  = '{0, 0};
   int   pcf[2]  = '{0, 0};
   bit   pw[2]   = '{0, 0};
   localparam logic [6:0] IDLE = 7'b1100000, STL = 7'b0001010,
                          HLD  = 7'b0000110, FLS = 7'b1110001;

   always @(negedge clk) begin
      logic [6:0] e, act;
      bit lu, mw, ctl, was_wait;
      lu  = id_ex_mem_read && (id_ex_rt != 0) &&
            ((id_uses_rs && id_rs == id_ex_rt) || (id_uses_rt && id_rt == id_ex_rt));
      mw  = mem_req && !mem_ready;
      ctl = branch_taken || jump || jump_reg;
      for (int i = 0; i < 2; i++) begin
         e = IDLE;
         if (rst) begin
            srem[i] = 0; frem[i] = 0; pw[i] = 0;
         end else if (mw) begin
            e = HLD; pw[i] = 1;
         end else begin
            was_wait = pw[i]; pw[i] = 0;
            if (srem[i] > 0)      begin e = STL; srem[i]--; end
            else if (frem[i] > 0) begin e = FLS; frem[i]--; end
            else if (was_wait)    e = IDLE;
            else if (lu)          begin e = STL; srem[i] = lat[i] - 1; end
            else if (ctl)         begin e = FLS; frem[i] = dep[i] - 1; end
         end
         act = (i == 0) ? {a_pc, a_ifw, a_ifl, a_bub, a_hold, a_stall, a_flush}
                        : {b_pc, b_ifw, b_ifl, b_bub, b_hold, b_stall, b_flush};
         chk(i == 0 ? "outs_lat1" : "outs_lat3", int'(act), int'(e));
`ifdef HAZARD_PERF_CNT_EN
         chk(i == 0 ? "scnt_a" : "scnt_b", i == 0 ? int'(a_scnt) : int'(b_scnt), pcs[i]);
         chk(i == 0 ? "fcnt_a" : "fcnt_b", i == 0 ? int'(a_fcnt) : int'(b_fcnt), pcf[i]);
`endif
         if (rst) begin
            pcs[i] = 0; pcf[i] = 0;
         end else begin
            if (!e[6] && pcs[i] < cap[i]) pcs[i]++;
            if (e[4] && pcf[i] < cap[i])  pcf[i]++;
         end
      end
      a_st += int'(a_stall); b_st += int'(b_stall);
      a_fl += int'(a_flush); b_fl += int'(b_flush);
      a_ho += int'(a_hold);  b_ho += int'(b_hold);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      {id_rs, id_rt, id_ex_rt} = '0;
      {id_uses_rs, id_uses_rt, id_ex_mem_read, mem_req, mem_ready} = '0;
      {branch_taken, jump, jump_reg} = '0;
   endtask

   task automatic set_lu(input logic [2:0] r);
      id_ex_mem_read = 1'b1; id_ex_rt = r; id_rs = r; id_uses_rs = 1'b1;
   endtask

   task automatic zero();
      a_st = 0; b_st = 0; a_fl = 0; b_fl = 0; a_ho = 0; b_ho = 0;
   endtask

   initial begin
      clr(); zero();
      // Reset overrides a live hazard and a memory wait
      rst = 1'b1; set_lu(3); mem_req = 1'b1; #1;
      chk("rst_pc_a", a_pc, 1); chk("rst_hold_b", b_hold, 0); chk("rst_bub_a", a_bub, 0);
      tick(); tick(); rst = 1'b0; clr(); tick();

      // Load-use on rs
      zero(); set_lu(3); #1;
      chk("lu_stall_a", a_stall, 1); chk("lu_bubble_a", a_bub, 1);
      tick(); clr(); #1;
      chk("lu_after_a", a_stall, 0); chk("lu_cont_b", b_stall, 1);
      repeat (4) tick();
      chk("lu_total_a", a_st, 1); chk("lu_total_b", b_st, 3);

      // Register 0 never hazards
      zero(); id_ex_mem_read = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      repeat (2) tick(); clr(); tick();
      chk("r0_a", a_st, 0); chk("r0_b", b_st, 0);

      // rt path hazards; unused operands do not
      zero(); id_ex_mem_read = 1'b1; id_ex_rt = 3'd5; id_rs = 3'd5; id_rt = 3'd5;
      #1 chk("unused_ops_a", a_stall, 0);
      id_uses_rt = 1'b1; tick(); clr(); repeat (3) tick();
      chk("rt_total_b", b_st, 3);

      // Load-use beats branch
      zero(); set_lu(3); branch_taken = 1'b1; tick(); clr(); repeat (4) tick();
      chk("lu_br_stall_a", a_st, 1); chk("lu_br_stall_b", b_st, 3);
      chk("lu_br_flush_a", a_fl, 0); chk("lu_br_flush_b", b_fl, 0);

      // Jump alone, jump_reg alone
      zero(); jump = 1'b1; #1 chk("jmp_pc_b", b_pc, 1);
      tick(); clr(); #1 chk("jmp_cont_b", b_flush, 1); chk("jmp_done_a", a_flush, 0);
      repeat (3) tick();
      chk("jmp_fl_a", a_fl, 1); chk("jmp_fl_b", b_fl, 2); chk("jmp_st_b", b_st, 0);
      zero(); jump_reg = 1'b1; tick(); clr(); repeat (3) tick();
      chk("jr_fl_a", a_fl, 1); chk("jr_fl_b", b_fl, 2);

      // Memory wait entered from LD_STALL with two cycles left
      zero(); set_lu(3); tick(); clr();
      mem_req = 1'b1; repeat (4) tick();
      mem_ready = 1'b1; #1 chk("mw_rel_b", b_stall, 1); chk("mw_rel_a", a_pc, 1);
      tick(); clr(); repeat (3) tick();
      chk("mw_hold_b", b_ho, 4); chk("mw_st_b", b_st, 7);
      chk("mw_hold_a", a_ho, 4); chk("mw_st_a", a_st, 5);

      // Memory wait during FLUSH, with a wrong-path jump ignored
      zero(); jump = 1'b1; tick(); clr(); mem_req = 1'b1; jump = 1'b1;
      repeat (2) tick(); clr(); repeat (3) tick();
      chk("mwf_fl_b", b_fl, 2); chk("mwf_hold_b", b_ho, 2); chk("mwf_fl_a", a_fl, 1);

      // Reset mid-flush
      zero(); jump = 1'b1; tick(); clr(); rst = 1'b1; #1 chk("rst_flush_b", b_flush, 0);
      tick(); rst = 1'b0; #1 chk("post_rst_fl_b", b_flush, 0); chk("post_rst_pc_b", b_pc, 1);
      tick(); jump = 1'b1; tick(); clr(); repeat (3) tick();
      chk("rst_flush_total_b", b_fl, 3);

`ifdef HAZARD_PERF_CNT_EN
      rst = 1'b1; tick(); rst = 1'b0; set_lu(3);
      repeat (5) tick();
      chk("perf5_a", a_scnt, 5); chk("perf5_b", b_scnt, 5);
      repeat (3) tick(); clr();
      chk("perf8_a", a_scnt, 8); chk("perf_sat_b", b_scnt, 7); chk("perf_fl_a", a_fcnt, 0);
      tick();
`endif

      // Counter sub-module saturation at CNT_W=3
      rst = 1'b1; tick(); rst = 1'b0;
      p_stall = 1'b1; p_flush = 1'b1; repeat (2) tick(); p_flush = 1'b0;
      repeat (3) tick();
      chk("pc_stall5", p_scnt, 5); chk("pc_flush2", p_fcnt, 2);
      repeat (4) tick(); p_stall = 1'b0;
      chk("pc_sat7", p_scnt, 7); chk("pc_flush_hold", p_fcnt, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
